// File: rtl/led_display_pattern_engine_pkg.sv
// Shared encodings and helpers for the LED matrix pattern engine.
// Plane indices follow the HUB row layout: top RGB in planes 0-2, bottom RGB in planes 3-5.
package led_display_pattern_engine_pkg;

  typedef enum logic [2:0] {
    LED_MODE_OFF     = 3'd0,
    LED_MODE_SOLID   = 3'd1,
    LED_MODE_SCAN_H  = 3'd2,
    LED_MODE_SCAN_V  = 3'd3,
    LED_MODE_PULSE   = 3'd4,
    LED_MODE_CHECKER = 3'd5
  } led_mode_e;

  typedef enum logic {
    ENG_IDLE   = 1'b0,
    ENG_STREAM = 1'b1
  } eng_state_e;

  localparam int PLANE_TOP_RED   = 0;
  localparam int PLANE_TOP_GREEN = 1;
  localparam int PLANE_TOP_BLUE  = 2;
  localparam int PLANE_BOT_RED   = 3;
  localparam int PLANE_BOT_GREEN = 4;
  localparam int PLANE_BOT_BLUE  = 5;

  // Widest row the plane helper handles; NUM_COLS must not exceed it.
  localparam int LED_MAX_COLS = 256;

  function automatic logic [LED_MAX_COLS-1:0] build_plane(
    input logic [LED_MAX_COLS-1:0] lit,
    input logic                    colour_en
  );
    return colour_en ? lit : '0;
  endfunction

  // Reserved mode codes render as OFF.
  function automatic led_mode_e decode_mode(input logic [2:0] raw);
    if (raw > 3'd5) return LED_MODE_OFF;
    return led_mode_e'(raw);
  endfunction

endpackage

// File: rtl/led_display_pattern_engine_if.sv
// Row-beat stream from the pattern engine to the row shifter / scan driver.
interface led_display_pattern_engine_if #(
  parameter int NUM_COLS   = 64,
  parameter int ROW_ADDR_W = 4
);
  logic [6*NUM_COLS-1:0]  row_out;
  logic                   row_valid_out;
  logic                   row_ready_in;
  logic [ROW_ADDR_W-1:0]  row_address_out;
  logic                   frame_start_out;

  // Handshake: row_valid_out rises on the first edge after reset and then stays high;
  // a beat transfers on every rising edge with valid && ready, and while ready is low
  // every row_* signal and frame_start_out hold their values.
  modport master (
    output row_out,
    output row_valid_out,
    output row_address_out,
    output frame_start_out,
    input  row_ready_in
  );

  modport slave (
    input  row_out,
    input  row_valid_out,
    input  row_address_out,
    input  frame_start_out,
    output row_ready_in
  );
endinterface

// File: rtl/led_effect_timebase.sv
// Free-running effect timebase: tick divider, scan positions, fade ramp,
// checker phase and the PWM comparison counter.
module led_effect_timebase
  import led_display_pattern_engine_pkg::*;
#(
  parameter int NUM_COLS   = 64,
  parameter int ROW_ADDR_W = 4,
  parameter int EFFECT_DIV = 1_000_000,
  parameter int PWM_BITS   = 8,
  parameter int PWM_DIV    = 20,
  localparam int H_W       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int V_W       = ROW_ADDR_W + 1
) (
  input  logic                clk_in,
  input  logic                n_reset_in,
  output logic [H_W-1:0]      h_pos_out,
  output logic [V_W-1:0]      v_pos_out,
  output logic [PWM_BITS-1:0] fade_out,
  output logic                phase_out,
  output logic [PWM_BITS-1:0] pwm_cnt_out
);

  localparam int ED_W = $clog2(EFFECT_DIV);
  localparam int PD_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  localparam logic [ED_W-1:0]     ED_LAST  = ED_W'(EFFECT_DIV - 1);
  localparam logic [PD_W-1:0]     PD_LAST  = PD_W'(PWM_DIV - 1);
  localparam logic [H_W-1:0]      H_LAST   = H_W'(NUM_COLS - 1);
  localparam logic [V_W-1:0]      V_LAST   = V_W'(2 * (2 ** ROW_ADDR_W) - 1);
  localparam logic [PWM_BITS-1:0] FADE_ONE = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] FADE_MAX = '1;

  logic [ED_W-1:0]     r_div;
  logic [PD_W-1:0]     r_pdiv;
  logic [H_W-1:0]      r_h_pos;
  logic [V_W-1:0]      r_v_pos;
  logic [PWM_BITS-1:0] r_fade;
  logic                r_fade_up;
  logic                r_phase;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  logic w_tick;
  logic w_pwm_step;

  assign w_tick     = (r_div == ED_LAST);
  assign w_pwm_step = (r_pdiv == PD_LAST);

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_div     <= '0;
      r_pdiv    <= '0;
      r_h_pos   <= '0;
      r_v_pos   <= '0;
      r_fade    <= '0;
      r_fade_up <= 1'b1;
      r_phase   <= 1'b0;
      r_pwm_cnt <= '0;
    end else begin
      r_div  <= w_tick ? '0 : r_div + ED_W'(1);
      r_pdiv <= w_pwm_step ? '0 : r_pdiv + PD_W'(1);
      if (w_pwm_step) r_pwm_cnt <= r_pwm_cnt + FADE_ONE;
      if (w_tick) begin
        r_h_pos <= (r_h_pos == H_LAST) ? '0 : r_h_pos + H_W'(1);
        r_v_pos <= (r_v_pos == V_LAST) ? '0 : r_v_pos + V_W'(1);
        r_phase <= ~r_phase;
        // Direction flips on the tick that lands on an extreme, so each extreme lasts one tick.
        if (r_fade_up) begin
          r_fade <= r_fade + FADE_ONE;
          if (r_fade == FADE_MAX - FADE_ONE) r_fade_up <= 1'b0;
        end else begin
          r_fade <= r_fade - FADE_ONE;
          if (r_fade == FADE_ONE) r_fade_up <= 1'b1;
        end
      end
    end
  end

  assign h_pos_out   = r_h_pos;
  assign v_pos_out   = r_v_pos;
  assign fade_out    = r_fade;
  assign phase_out   = r_phase;
  assign pwm_cnt_out = r_pwm_cnt;

endmodule

// File: rtl/led_display_pattern_engine.sv
// Pattern source for the HUB LED matrix driver: emits one top/bottom row pair per beat,
// with mode, colour and effect state frozen per frame so a frame never tears.
module led_display_pattern_engine
  import led_display_pattern_engine_pkg::*;
#(
  parameter int NUM_COLS   = 64,
  parameter int ROW_ADDR_W = 4,
  parameter int EFFECT_DIV = 1_000_000,
  parameter int PWM_BITS   = 8,
  parameter int PWM_DIV    = 20,
  parameter int CHECK_LOG2 = 2
) (
  input  logic        clk_in,
  input  logic        n_reset_in,
  input  logic [2:0]  colour_in,
  input  logic [2:0]  mode_in,
  output logic [2:0]  mode_active_out,
  output eng_state_e  debug_state_out,
  led_display_pattern_engine_if.master row_if
);

  localparam int H_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int V_W = ROW_ADDR_W + 1;

  logic [H_W-1:0]      w_h_pos;
  logic [V_W-1:0]      w_v_pos;
  logic [PWM_BITS-1:0] w_fade;
  logic                w_phase;
  logic [PWM_BITS-1:0] w_pwm_cnt;

  led_effect_timebase #(
    .NUM_COLS   (NUM_COLS),
    .ROW_ADDR_W (ROW_ADDR_W),
    .EFFECT_DIV (EFFECT_DIV),
    .PWM_BITS   (PWM_BITS),
    .PWM_DIV    (PWM_DIV)
  ) u_timebase (
    .clk_in      (clk_in),
    .n_reset_in  (n_reset_in),
    .h_pos_out   (w_h_pos),
    .v_pos_out   (w_v_pos),
    .fade_out    (w_fade),
    .phase_out   (w_phase),
    .pwm_cnt_out (w_pwm_cnt)
  );

  eng_state_e            r_state;
  logic                  r_valid;
  logic [ROW_ADDR_W-1:0] r_addr;
  logic                  r_frame_start;
  logic [6*NUM_COLS-1:0] r_row;

  led_mode_e             r_snap_mode;
  logic [2:0]            r_snap_colour;
  logic [H_W-1:0]        r_snap_h;
  logic [V_W-1:0]        r_snap_v;
  logic [PWM_BITS-1:0]   r_snap_fade;
  logic                  r_snap_phase;

  logic                  w_load;
  logic [ROW_ADDR_W-1:0] w_line;
  logic                  w_new_frame;
  led_mode_e             w_eff_mode;
  logic [2:0]            w_eff_colour;
  logic [H_W-1:0]        w_eff_h;
  logic [V_W-1:0]        w_eff_v;
  logic [PWM_BITS-1:0]   w_eff_fade;
  logic                  w_eff_phase;

  assign w_load      = (r_state == ENG_IDLE) || (r_valid && row_if.row_ready_in);
  assign w_line      = (r_state == ENG_IDLE) ? '0 : r_addr + ROW_ADDR_W'(1);
  assign w_new_frame = (w_line == '0);

  // A row-0 beat renders from the values being snapshotted on this same edge.
  assign w_eff_mode   = w_new_frame ? decode_mode(mode_in) : r_snap_mode;
  assign w_eff_colour = w_new_frame ? colour_in : r_snap_colour;
  assign w_eff_h      = w_new_frame ? w_h_pos   : r_snap_h;
  assign w_eff_v      = w_new_frame ? w_v_pos   : r_snap_v;
  assign w_eff_fade   = w_new_frame ? w_fade    : r_snap_fade;
  assign w_eff_phase  = w_new_frame ? w_phase   : r_snap_phase;

  logic [NUM_COLS-1:0]   w_top_lit;
  logic [NUM_COLS-1:0]   w_bot_lit;
  logic                  w_pulse_on;
  logic                  w_vscan_top;
  logic                  w_vscan_bot;
  logic                  w_chk_top_row;
  logic                  w_chk_bot_row;

  always_comb begin
    w_top_lit     = '0;
    w_bot_lit     = '0;
    w_pulse_on    = (w_pwm_cnt < w_eff_fade);
    w_vscan_top   = !w_eff_v[ROW_ADDR_W] && (w_eff_v[ROW_ADDR_W-1:0] == w_line);
    w_vscan_bot   =  w_eff_v[ROW_ADDR_W] && (w_eff_v[ROW_ADDR_W-1:0] == w_line);
    // Bottom-half lines continue the top-half numbering at ROWS, i.e. {1, line}.
    w_chk_top_row = 1'(32'({1'b0, w_line}) >> CHECK_LOG2);
    w_chk_bot_row = 1'(32'({1'b1, w_line}) >> CHECK_LOG2);
    for (int c = 0; c < NUM_COLS; c++) begin
      case (w_eff_mode)
        LED_MODE_SOLID: begin
          w_top_lit[c] = 1'b1;
          w_bot_lit[c] = 1'b1;
        end
        LED_MODE_SCAN_H: begin
          w_top_lit[c] = (H_W'(c) == w_eff_h);
          w_bot_lit[c] = (H_W'(c) == w_eff_h);
        end
        LED_MODE_SCAN_V: begin
          w_top_lit[c] = w_vscan_top;
          w_bot_lit[c] = w_vscan_bot;
        end
        LED_MODE_PULSE: begin
          w_top_lit[c] = w_pulse_on;
          w_bot_lit[c] = w_pulse_on;
        end
        LED_MODE_CHECKER: begin
          w_top_lit[c] = 1'(c >> CHECK_LOG2) ^ w_chk_top_row ^ w_eff_phase;
          w_bot_lit[c] = 1'(c >> CHECK_LOG2) ^ w_chk_bot_row ^ w_eff_phase;
        end
        default: begin
          w_top_lit[c] = 1'b0;
          w_bot_lit[c] = 1'b0;
        end
      endcase
    end
  end

  logic [6*NUM_COLS-1:0] w_row;

  always_comb begin
    w_row = '0;
    w_row[PLANE_TOP_RED*NUM_COLS   +: NUM_COLS] = NUM_COLS'(build_plane(LED_MAX_COLS'(w_top_lit), w_eff_colour[0]));
    w_row[PLANE_TOP_GREEN*NUM_COLS +: NUM_COLS] = NUM_COLS'(build_plane(LED_MAX_COLS'(w_top_lit), w_eff_colour[1]));
    w_row[PLANE_TOP_BLUE*NUM_COLS  +: NUM_COLS] = NUM_COLS'(build_plane(LED_MAX_COLS'(w_top_lit), w_eff_colour[2]));
    w_row[PLANE_BOT_RED*NUM_COLS   +: NUM_COLS] = NUM_COLS'(build_plane(LED_MAX_COLS'(w_bot_lit), w_eff_colour[0]));
    w_row[PLANE_BOT_GREEN*NUM_COLS +: NUM_COLS] = NUM_COLS'(build_plane(LED_MAX_COLS'(w_bot_lit), w_eff_colour[1]));
    w_row[PLANE_BOT_BLUE*NUM_COLS  +: NUM_COLS] = NUM_COLS'(build_plane(LED_MAX_COLS'(w_bot_lit), w_eff_colour[2]));
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_state       <= ENG_IDLE;
      r_valid       <= 1'b0;
      r_addr        <= '0;
      r_frame_start <= 1'b0;
      r_row         <= '0;
      r_snap_mode   <= LED_MODE_OFF;
      r_snap_colour <= '0;
      r_snap_h      <= '0;
      r_snap_v      <= '0;
      r_snap_fade   <= '0;
      r_snap_phase  <= 1'b0;
    end else if (w_load) begin
      r_state       <= ENG_STREAM;
      r_valid       <= 1'b1;
      r_addr        <= w_line;
      r_frame_start <= w_new_frame;
      r_row         <= w_row;
      if (w_new_frame) begin
        r_snap_mode   <= w_eff_mode;
        r_snap_colour <= w_eff_colour;
        r_snap_h      <= w_eff_h;
        r_snap_v      <= w_eff_v;
        r_snap_fade   <= w_eff_fade;
        r_snap_phase  <= w_eff_phase;
      end
    end
  end

  assign row_if.row_out         = r_row;
  assign row_if.row_valid_out   = r_valid;
  assign row_if.row_address_out = r_addr;
  assign row_if.frame_start_out = r_frame_start;
  assign mode_active_out        = r_snap_mode;
  assign debug_state_out        = r_state;

endmodule

// File: tb/tb_led_display_pattern_engine.sv
// Directed bench for led_display_pattern_engine with small parameters (8 columns, 4 rows per half).
module tb_led_display_pattern_engine;
  import led_display_pattern_engine_pkg::*;

  localparam int NC   = 8;
  localparam int RAW  = 2;
  localparam int ROWS = 4;
  localparam int ED   = 10;
  localparam int PB   = 3;
  localparam int PD   = 1;
  localparam int CL   = 1;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] colour;
  logic [2:0] mode;
  logic [2:0] mode_act;
  eng_state_e dbg_state;

  always #5 clk = ~clk;

  led_display_pattern_engine_if #(.NUM_COLS(NC), .ROW_ADDR_W(RAW)) row_bus ();

  led_display_pattern_engine #(
    .NUM_COLS   (NC),
    .ROW_ADDR_W (RAW),
    .EFFECT_DIV (ED),
    .PWM_BITS   (PB),
    .PWM_DIV    (PD),
    .CHECK_LOG2 (CL)
  ) dut (
    .clk_in          (clk),
    .n_reset_in      (rst_n),
    .colour_in       (colour),
    .mode_in         (mode),
    .mode_active_out (mode_act),
    .debug_state_out (dbg_state),
    .row_if          (row_bus)
  );

  // Rising edges since the last reset release; the timebase counts from the same point.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_cmp;
  int          n_bad;
  logic [47:0] exp_q[$];
  int          exp_addr;
  int          snap_cyc;
  int          load_cyc;
  int          frame_mode;
  logic [2:0]  frame_colour;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // k = effect ticks completed before the frame snapshot, pwm = PWM count at beat load.
  function automatic logic [47:0] exp_row(input int m, input logic [2:0] col,
                                          input int line, input int k, input int pwm);
    int h, v, ph, kk, fade;
    logic [7:0] top, bot;
    h  = k % 8;
    v  = k % 8;
    ph = k % 2;
    kk = k % 14;
    fade = (kk <= 7) ? kk : 14 - kk;
    top = '0;
    bot = '0;
    for (int c = 0; c < 8; c++) begin
      case (m)
        1: begin top[c] = 1'b1;          bot[c] = 1'b1;          end
        2: begin top[c] = (c == h);      bot[c] = (c == h);      end
        3: begin top[c] = (v < 4 && line == v); bot[c] = (v >= 4 && line == v - 4); end
        4: begin top[c] = (pwm < fade);  bot[c] = (pwm < fade);  end
        5: begin
          top[c] = ((c / 2 + line / 2 + ph) % 2) == 1;
          bot[c] = ((c / 2 + (line + 4) / 2 + ph) % 2) == 1;
        end
        default: ;
      endcase
    end
    return {col[2] ? bot : 8'h00, col[1] ? bot : 8'h00, col[0] ? bot : 8'h00,
            col[2] ? top : 8'h00, col[1] ? top : 8'h00, col[0] ? top : 8'h00};
  endfunction

  task automatic load_beat();
    load_cyc = cyc;
    if (exp_addr == 0) begin
      snap_cyc     = cyc;
      frame_mode   = (mode > 3'd5) ? 0 : int'(mode);
      frame_colour = colour;
    end
    exp_q.push_back(exp_row(frame_mode, frame_colour, exp_addr, (snap_cyc - 1) / ED, (load_cyc - 1) % 8));
  endtask

  task automatic check_beat();
    while (exp_q.size() > 1) exp_q.delete(0);
    chk("valid",       64'(row_bus.row_valid_out),   64'(1));
    chk("addr",        64'(row_bus.row_address_out), 64'(exp_addr));
    chk("frame_start", 64'(row_bus.frame_start_out), 64'(exp_addr == 0));
    chk("mode_active", 64'(mode_act),                64'(frame_mode));
    chk("row",         64'(row_bus.row_out),         64'(exp_q[0]));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_row"},   64'(row_bus.row_out),         64'(0));
    chk({tag, "_valid"}, 64'(row_bus.row_valid_out),   64'(0));
    chk({tag, "_addr"},  64'(row_bus.row_address_out), 64'(0));
    chk({tag, "_fs"},    64'(row_bus.frame_start_out), 64'(0));
    chk({tag, "_mode"},  64'(mode_act),                64'(0));
    chk({tag, "_state"}, 64'(dbg_state),               64'(ENG_IDLE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic first_beat();
    @(negedge clk);
    exp_addr = 0;
    load_beat();
    check_beat();
    chk("state_stream", 64'(dbg_state), 64'(ENG_STREAM));
  endtask

  task automatic advance(input logic rdy);
    row_bus.row_ready_in = rdy;
    @(negedge clk);
    if (rdy) begin
      exp_addr = (exp_addr + 1) % ROWS;
      load_beat();
    end
    check_beat();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_addr = 0;
    snap_cyc = 1;
    load_cyc = 1;
    frame_mode = 0;
    frame_colour = '0;
    mode   = 3'd1;
    colour = 3'b101;
    row_bus.row_ready_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    // SOLID red+blue, continuous ready
    first_beat();
    chk("solid_literal", 64'(row_bus.row_out), 64'(48'hFF00FF_FF00FF));
    repeat (11) advance(1'b1);

    // random back-pressure, colour change lands at the next frame
    colour = 3'b110;
    repeat (60) advance(1'($urandom_range(0, 1)));

    // mode switch to SCAN_H while address 1 is on the bus
    mode   = 3'd1;
    colour = 3'b101;
    repeat (5) advance(1'b1);
    for (int i = 0; i < 8 && exp_addr != 1; i++) advance(1'b1);
    mode = 3'd2;
    repeat (8) advance(1'b1);

    // SCAN_V across more than 80 ticks
    mode   = 3'd3;
    colour = 3'b111;
    repeat (820) advance(1'b1);

    // PULSE over two full fade periods
    mode   = 3'd4;
    colour = 3'b101;
    repeat (300) advance(1'b1);

    // CHECKER with back-pressure, then a reserved code
    mode   = 3'd5;
    colour = 3'b010;
    repeat (40) advance(1'($urandom_range(0, 1)));
    mode = 3'd6;
    repeat (12) advance(1'b1);

    // asynchronous reset mid-frame while stalled
    mode = 3'd1;
    repeat (2) advance(1'b1);
    repeat (2) advance(1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset("async");
    exp_q.delete();
    @(negedge clk);
    check_reset("held");
    mode   = 3'd1;
    colour = 3'b011;
    row_bus.row_ready_in = 1'b0;
    rst_n = 1'b1;
    first_beat();
    chk("restart_fs_literal", 64'(row_bus.frame_start_out), 64'(1));
    advance(1'b0);
    repeat (6) advance(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/led_display_pattern_engine.md
# led_display_pattern_engine

Parametrised pattern source for the HUB-style LED matrix driver. It generates one display row pair (top and bottom half) per handshake beat. Modes are OFF, SOLID, H-scan, V-scan, PULSE and CHECKER, with colour depth 1 bit/channel. Mode, colour and effect state are sampled once per frame so a frame never tears. It sits between the control/register block (mode, colour) and the row shifter/scan driver (valid/ready consumer).

## Interface
- NUM_COLS, 64, pixels per row line.
- ROW_ADDR_W, 4, row address width; rows per half ROWS = 2**ROW_ADDR_W.
- EFFECT_DIV, 1_000_000, clocks per effect tick (≥2).
- PWM_BITS, 8, fade/PWM resolution.
- PWM_DIV, 20, clocks per PWM counter step (≥1).
- CHECK_LOG2, 2, checker square size 2**CHECK_LOG2 pixels.
---
- clk_in  in  1  system clock; one clock; all logic on rising edge.
- n_reset_in  in  1  reset, asynchronous and active-low.
- colour_in  in  3  {blue, green, red} enable.
- mode_in  in  3  0 OFF, 1 SOLID, 2 SCAN_H, 3 SCAN_V, 4 PULSE, 5 CHECKER; 6–7 reserved.
- row_out  out  6*NUM_COLS  plane k at [k*NUM_COLS +: NUM_COLS]: k = 0 top red, 1 top green, 2 top blue, 3 bot red, 4 bot green, 5 bot blue; bit c is column c.
- row_valid_out  out  1  beat valid.
- row_ready_in  in  1  consumer ready.
- row_address_out  out  ROW_ADDR_W  row line of current beat.
- frame_start_out  out  1  high with the row-0 beat.
- mode_active_out  out  3  mode used by the current frame.

## Operation
- Reset values: row_out 0, row_valid_out 0, row_address_out 0, frame_start_out 0, mode_active_out 0. All internal counters are 0. Fade direction is up.
- First edge after reset release: load beat 0 (row 0, frame snapshot taken) and set row_valid_out to 1.
- Transfer occurs when valid && ready. On a transfer edge, load the next beat: address+1, wrapping ROWS-1 → 0.
- row_valid_out stays 1 after the first load. It deasserts only on reset.
- While valid && !ready, every output is held stable.
- Frame snapshot is taken when a row-0 beat is loaded. It latches mode_in (reserved values become OFF), colour_in, h_pos, v_pos, fade and checker phase. Mid-frame changes on mode_in or colour_in have no effect until the next frame.
- Effect tick: counter 0..EFFECT_DIV-1 pulses tick on wrap. Effects advance on tick in every mode.
- h_pos 0..NUM_COLS-1 increments and wraps. v_pos 0..2*ROWS-1 increments and wraps. Checker phase toggles.
- fade (PWM_BITS): increments when up, decrements when down. Direction flips on the tick that reaches max (2**PWM_BITS-1) or 0, so each extreme is held for exactly one tick period.
- PWM counter (PWM_BITS) increments every PWM_DIV clocks, free-running. It is live and not snapshotted.
- Pixel lit value for column c, line L, with a colour plane enabled by the snapshot colour:
  - OFF: 0.
  - SOLID: 1.
  - SCAN_H: c == h_pos, in both halves.
  - SCAN_V: top half lit when v_pos < ROWS and L == v_pos. Bottom half lit when v_pos ≥ ROWS and L == v_pos-ROWS.
  - PULSE: pwm_cnt < fade, evaluated at beat load time.
  - CHECKER: c[CHECK_LOG2] ^ L'[CHECK_LOG2] ^ phase. L' = L for the top half and L+ROWS for the bottom half.
- A disabled colour plane is always 0.

## Timing
- Throughput: one beat per cycle under continuous ready. Row n+1 appears the cycle after row n transfers.
- Latency from transfer to next beat: 1 cycle.
- frame_start_out is registered with the beat and follows the same hold rule.
- A tick coinciding with a row-0 load does not enter the snapshot. The snapshot uses pre-tick values.
- Reset asserted mid-frame or mid-beat clears all outputs immediately, without waiting for a clock. The restart is identical to power-up.

## Structure
- Shared package holds:
  - mode encodings (LED_MODE_OFF..LED_MODE_CHECKER);
  - plane index constants (PLANE_TOP_RED..PLANE_BOT_BLUE);
  - a function that builds a plane from a lit mask and a colour bit.
- Sub-module led_effect_timebase contains:
  - the tick divider;
  - the h_pos, v_pos, fade and phase registers;
  - the PWM counter.
- The top level holds the handshake, the address counter, the snapshot registers and the pixel generation.

## Test plan
Bench parameters: NUM_COLS=8, ROW_ADDR_W=2, EFFECT_DIV=10, PWM_BITS=3, PWM_DIV=1, CHECK_LOG2=1.

1. SOLID, colour 3'b101, ready held 1 → each frame carries addresses 0,1,2,3. Every beat shows top red = bot red = 8'hFF and blue = 8'hFF, green = 0. frame_start is 1 only at address 0.
2. Ready toggled randomly → data, address and frame_start stay constant while valid && !ready. There are no skipped or duplicated addresses.
3. mode_in switched SOLID→SCAN_H at address 1 → rows 1–3 remain SOLID. The next row 0 shows mode_active_out = 2 and a single lit column at h_pos.
4. SCAN_V run for 80 ticks → the lit line walks top rows 0–3, then bottom rows 0–3, then wraps to top row 0.
5. PULSE → fade sequence 0,1,…,7,6,…,0,1. At fade 0 all pixels are 0. At fade 7, 7 of every 8 PWM phases are lit.
6. Reset asserted mid-frame with ready=0 → all outputs are 0 asynchronously. After release, the first beat is address 0 with frame_start=1.
